// File: rtl/fe_fifo_packer_pkg.sv
// Shared definitions for the front-end FIFO packer: command codes,
// 18-bit FIFO word field positions and the packer FSM state type.
package fe_fifo_packer_pkg;

    // Capture command codes carried in the top two bits of every FIFO word.
    localparam logic [1:0] FE_FIFO_CMD_DATA   = 2'd0;
    localparam logic [1:0] FE_FIFO_CMD_TIME   = 2'd1;
    localparam logic [1:0] FE_FIFO_CMD_STROBE = 2'd2;
    localparam logic [1:0] FE_FIFO_CMD_MARK   = 2'd3;

    // Field positions inside the packed FIFO word.
    localparam int FE_WORD_WIDTH = 18;
    localparam int CMD_MSB       = 17;
    localparam int CMD_LSB       = 16;
    localparam int SHORT_TS_MSB  = 15;
    localparam int SHORT_TS_LSB  = 8;
    localparam int DATA_MSB      = 7;
    localparam int DATA_LSB      = 0;
    // TIME words reuse everything below the command field for the timestamp.
    localparam int TIME_MSB      = 15;
    localparam int TIME_LSB      = 0;

    typedef enum logic {
        ST_ACTIVE  = 1'b0,
        ST_BLOCKED = 1'b1
    } fe_pack_state_t;

endpackage

// File: rtl/fe_packer_buf.sv
// Small synchronous circular buffer used as the packer's elastic stage.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
// The head entry is read combinationally so a word can leave the cycle
// after it is written.
module fe_packer_buf #(
    parameter int WIDTH      = 18,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  fe_clk,
    input  logic                  reset_i,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_reg [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_reg;
    logic [DEPTH_LOG2:0] rd_ptr_reg;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                     (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign rd_data = mem_reg[rd_ptr_reg[DEPTH_LOG2-1:0]];

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge fe_clk) begin
        if (push && !flush && !reset_i) begin
            mem_reg[wr_ptr_reg[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Pointer update; flush and reset both return the buffer to empty.
    always_ff @(posedge fe_clk) begin
        if (reset_i || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fe_fifo_packer.sv
// Front-end FIFO packer: packs one capture event per cycle into an 18-bit
// word, buffers it in a small elastic stage ahead of the main capture FIFO
// and reports dropped events back to the capture FSM.
// Optional build macro FE_PACKER_STATS_EN adds O_words_written/O_max_level.
module fe_fifo_packer
    import fe_fifo_packer_pkg::*;
#(
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int pDEPTH_LOG2            = 2,
    parameter int pDROP_CNT_WIDTH        = 16
) (
    input  logic                             fe_clk,
    input  logic                             reset_i,
    input  logic                             I_fifo_wr,
    input  logic [1:0]                       I_fifo_command,
    input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_fifo_time,
    input  logic [7:0]                       I_fifo_data,
    input  logic                             I_flush,
    input  logic                             I_full,
    output logic                             O_wr_en,
    output logic [FE_WORD_WIDTH-1:0]         O_wr_data,
    output logic                             O_overflow_blocked,
    output logic                             O_clamped,
    output logic [pDROP_CNT_WIDTH-1:0]       O_drop_count,
    output logic [pDEPTH_LOG2:0]             O_level
`ifdef FE_PACKER_STATS_EN
    ,
    output logic [31:0]                      O_words_written,
    output logic [pDEPTH_LOG2:0]             O_max_level
`endif
);

    // Largest timestamp that fits the short field unsaturated.
    localparam logic [pTIMESTAMP_FULL_WIDTH-1:0] SHORT_TS_MAX =
        {{(pTIMESTAMP_FULL_WIDTH-pTIMESTAMP_SHORT_WIDTH){1'b0}},
         {pTIMESTAMP_SHORT_WIDTH{1'b1}}};

    fe_pack_state_t               state_reg;
    logic                         overflow_reg;
    logic                         clamped_reg;
    logic [pDROP_CNT_WIDTH-1:0]   drop_cnt_reg;

    logic                         buf_full;
    logic                         buf_empty;
    logic                         push;
    logic                         pop;
    logic                         drop;
    logic                         ts_over;
    logic                         is_time_cmd;
    logic [7:0]                   short_ts;
    logic [FE_WORD_WIDTH-1:0]     packed_word;
    logic [FE_WORD_WIDTH-1:0]     head_word;
    logic [pDEPTH_LOG2:0]         level;

    assign is_time_cmd = (I_fifo_command == FE_FIFO_CMD_TIME);
    assign ts_over     = (I_fifo_time > SHORT_TS_MAX);

    // Handshake: pop whenever a word is waiting and downstream has room;
    // push may reuse the slot freed by a same-cycle pop.
    assign pop  = !buf_empty && !I_full;
    assign push = I_fifo_wr && !I_flush && (state_reg == ST_ACTIVE) && (!buf_full || pop);
    assign drop = I_fifo_wr && !I_flush && !push;

    // Saturate the short timestamp and zero-extend it to the 8-bit field.
    always_comb begin
        short_ts = '0;
        short_ts[pTIMESTAMP_SHORT_WIDTH-1:0] =
            ts_over ? {pTIMESTAMP_SHORT_WIDTH{1'b1}} : I_fifo_time[pTIMESTAMP_SHORT_WIDTH-1:0];
    end

    // Build the FIFO word: TIME carries the full timestamp, others short ts + data.
    always_comb begin
        packed_word                   = '0;
        packed_word[CMD_MSB:CMD_LSB]  = I_fifo_command;
        if (is_time_cmd) begin
            packed_word[TIME_MSB:TIME_LSB] = I_fifo_time[TIME_MSB:TIME_LSB];
        end else begin
            packed_word[SHORT_TS_MSB:SHORT_TS_LSB] = short_ts;
            packed_word[DATA_MSB:DATA_LSB]         = I_fifo_data;
        end
    end

    fe_packer_buf #(
        .WIDTH      (FE_WORD_WIDTH),
        .DEPTH_LOG2 (pDEPTH_LOG2)
    ) u_buf (
        .fe_clk  (fe_clk),
        .reset_i (reset_i),
        .flush   (I_flush),
        .push    (push),
        .pop     (pop),
        .wr_data (packed_word),
        .rd_data (head_word),
        .full    (buf_full),
        .empty   (buf_empty),
        .level   (level)
    );

    // Overflow FSM with its sticky flags and saturating drop counter.
    always_ff @(posedge fe_clk) begin
        if (reset_i || I_flush) begin
            state_reg    <= ST_ACTIVE;
            overflow_reg <= 1'b0;
            clamped_reg  <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_ACTIVE: begin
                    if (drop) begin
                        state_reg    <= ST_BLOCKED;
                        overflow_reg <= 1'b1;
                    end
                end
                ST_BLOCKED: begin
                    state_reg <= ST_BLOCKED;
                end
                default: begin
                    state_reg <= ST_ACTIVE;
                end
            endcase
            if (drop && (drop_cnt_reg != {pDROP_CNT_WIDTH{1'b1}})) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
            if (push && !is_time_cmd && ts_over) begin
                clamped_reg <= 1'b1;
            end
        end
    end

    assign O_wr_en            = pop;
    assign O_wr_data          = head_word;
    assign O_overflow_blocked = overflow_reg;
    assign O_clamped          = clamped_reg;
    assign O_drop_count       = drop_cnt_reg;
    assign O_level            = level;

`ifdef FE_PACKER_STATS_EN
    logic [31:0]          words_written_reg;
    logic [pDEPTH_LOG2:0] max_level_reg;

    // Pop counter (wrapping) and occupancy high-water mark, cleared on flush.
    always_ff @(posedge fe_clk) begin
        if (reset_i || I_flush) begin
            words_written_reg <= '0;
            max_level_reg     <= '0;
        end else begin
            if (pop) begin
                words_written_reg <= words_written_reg + 32'd1;
            end
            if (level > max_level_reg) begin
                max_level_reg <= level;
            end
        end
    end

    assign O_words_written = words_written_reg;
    assign O_max_level     = max_level_reg;
`endif

endmodule

// File: tb/tb_fe_fifo_packer.sv
// Self-checking bench for fe_fifo_packer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_fe_fifo_packer;
    import fe_fifo_packer_pkg::*;

    localparam int DEPTH    = 4;
    localparam int SMAX     = 7;
    localparam int DROP_MAX = 65535;

    logic        fe_clk = 1'b0;
    logic        reset_i;
    logic        I_fifo_wr;
    logic [1:0]  I_fifo_command;
    logic [15:0] I_fifo_time;
    logic [7:0]  I_fifo_data;
    logic        I_flush;
    logic        I_full;
    logic        O_wr_en;
    logic [17:0] O_wr_data;
    logic        O_overflow_blocked;
    logic        O_clamped;
    logic [15:0] O_drop_count;
    logic [2:0]  O_level;
`ifdef FE_PACKER_STATS_EN
    logic [31:0] O_words_written;
    logic [2:0]  O_max_level;
`endif

    fe_fifo_packer dut (
        .fe_clk             (fe_clk),
        .reset_i            (reset_i),
        .I_fifo_wr          (I_fifo_wr),
        .I_fifo_command     (I_fifo_command),
        .I_fifo_time        (I_fifo_time),
        .I_fifo_data        (I_fifo_data),
        .I_flush            (I_flush),
        .I_full             (I_full),
        .O_wr_en            (O_wr_en),
        .O_wr_data          (O_wr_data),
        .O_overflow_blocked (O_overflow_blocked),
        .O_clamped          (O_clamped),
        .O_drop_count       (O_drop_count),
        .O_level            (O_level)
`ifdef FE_PACKER_STATS_EN
        ,
        .O_words_written    (O_words_written),
        .O_max_level        (O_max_level)
`endif
    );

    always #5 fe_clk = ~fe_clk;

    // Reference model state
    logic [17:0] q[$];
    bit          m_blocked;
    bit          m_clamped;
    int          m_drops;
    int unsigned m_words;
    int          m_maxlvl;
    bit          chk_en;

    int n_vec;
    int n_err;

    function automatic logic [17:0] pack_ref(input logic [1:0] cmd, input logic [15:0] t,
                                             input logic [7:0] d);
        logic [7:0] ts;
        if (cmd == FE_FIFO_CMD_TIME) return {cmd, t};
        ts = (int'(t) > SMAX) ? 8'(SMAX) : t[7:0];
        return {cmd, ts, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cyc(input bit wr, input logic [1:0] cmd, input logic [15:0] t,
                       input logic [7:0] d, input bit fl, input bit fu, input bit rs);
        bit exp_en;
        bit accept;
        reset_i        = rs;
        I_fifo_wr      = wr;
        I_fifo_command = cmd;
        I_fifo_time    = t;
        I_fifo_data    = d;
        I_flush        = fl;
        I_full         = fu;
        #1;
        exp_en = (q.size() != 0) && !fu;
        if (chk_en) begin
            chk("wr_en", 32'(O_wr_en), 32'(exp_en));
            if (q.size() != 0) chk("wr_data", 32'(O_wr_data), 32'(q[0]));
            chk("level", 32'(O_level), 32'(q.size()));
            chk("overflow", 32'(O_overflow_blocked), 32'(m_blocked));
            chk("clamped", 32'(O_clamped), 32'(m_clamped));
            chk("drops", 32'(O_drop_count), 32'(m_drops));
`ifdef FE_PACKER_STATS_EN
            chk("words", O_words_written, 32'(m_words));
            chk("maxlvl", 32'(O_max_level), 32'(m_maxlvl));
`endif
        end
        @(posedge fe_clk);
        if (rs || fl) begin
            q.delete();
            m_blocked = 0;
            m_clamped = 0;
            m_drops   = 0;
            m_words   = 0;
            m_maxlvl  = 0;
        end else begin
            if (q.size() > m_maxlvl) m_maxlvl = q.size();
            accept = wr && !m_blocked && ((q.size() < DEPTH) || exp_en);
            if (wr && !accept) begin
                m_blocked = 1;
                if (m_drops < DROP_MAX) m_drops++;
            end
            if (exp_en) begin
                void'(q.pop_front());
                m_words++;
            end
            if (accept) begin
                if (cmd != FE_FIFO_CMD_TIME && int'(t) > SMAX) m_clamped = 1;
                q.push_back(pack_ref(cmd, t, d));
            end
        end
        @(negedge fe_clk);
    endtask

    task automatic idle(input bit fu);
        cyc(1'b0, 2'd0, 16'd0, 8'd0, 1'b0, fu, 1'b0);
    endtask

    task automatic ev(input logic [1:0] cmd, input logic [15:0] t, input logic [7:0] d,
                      input bit fu);
        cyc(1'b1, cmd, t, d, 1'b0, fu, 1'b0);
    endtask

    initial begin
        logic [17:0] w;
        n_vec  = 0;
        n_err  = 0;
        chk_en = 0;
        @(negedge fe_clk);
        cyc(1'b0, 2'd0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk_en = 1;
        idle(1'b0);

        // Data event appears the next cycle with short timestamp 5
        ev(FE_FIFO_CMD_DATA, 16'd5, 8'hA5, 1'b0);
        w = {FE_FIFO_CMD_DATA, 8'h05, 8'hA5};
        chk("t1_data", 32'(O_wr_data), 32'(w));
        chk("t1_en", 32'(O_wr_en), 32'd1);
        idle(1'b0);
        chk("t1_level", 32'(O_level), 32'd0);

        // TIME word keeps all 16 bits; large time on DATA saturates
        ev(FE_FIFO_CMD_TIME, 16'h1234, 8'h00, 1'b0);
        w = {FE_FIFO_CMD_TIME, 16'h1234};
        chk("t2_time", 32'(O_wr_data), 32'(w));
        ev(FE_FIFO_CMD_DATA, 16'd12, 8'h3C, 1'b0);
        w = {FE_FIFO_CMD_DATA, 8'h07, 8'h3C};
        chk("t2_clamp_word", 32'(O_wr_data), 32'(w));
        chk("t2_clamped", 32'(O_clamped), 32'd1);
        idle(1'b0);

        // Back-pressure overflow: 6 events into depth 4
        cyc(1'b0, 2'd0, 16'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) ev(FE_FIFO_CMD_STROBE, 16'(i), 8'(8'h10 + i), 1'b1);
        chk("t3_ovf", 32'(O_overflow_blocked), 32'd1);
        chk("t3_drops", 32'(O_drop_count), 32'd2);
        chk("t3_level", 32'(O_level), 32'd4);
        for (int i = 0; i < 6; i++) idle(1'b0);
        chk("t3_drained", 32'(O_level), 32'd0);

        // Full buffer with simultaneous push and pop
        cyc(1'b0, 2'd0, 16'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ev(FE_FIFO_CMD_MARK, 16'(i), 8'(i), 1'b1);
        for (int i = 0; i < 10; i++) ev(FE_FIFO_CMD_DATA, 16'(i), 8'(8'h80 + i), 1'b0);
        chk("t4_level", 32'(O_level), 32'd4);
        chk("t4_drops", 32'(O_drop_count), 32'd0);

        // Block, then flush with a concurrent event
        ev(FE_FIFO_CMD_DATA, 16'd1, 8'h55, 1'b1);
        chk("t5_blocked", 32'(O_overflow_blocked), 32'd1);
        cyc(1'b1, FE_FIFO_CMD_DATA, 16'd2, 8'h66, 1'b1, 1'b1, 1'b0);
        chk("t5_level", 32'(O_level), 32'd0);
        chk("t5_drops", 32'(O_drop_count), 32'd0);
        chk("t5_ovf", 32'(O_overflow_blocked), 32'd0);
        ev(FE_FIFO_CMD_DATA, 16'd3, 8'h77, 1'b0);
        chk("t5_accept", 32'(O_wr_en), 32'd1);
        idle(1'b0);

        // Reset mid-burst with the buffer half full
        ev(FE_FIFO_CMD_DATA, 16'd1, 8'h01, 1'b1);
        ev(FE_FIFO_CMD_DATA, 16'd2, 8'h02, 1'b1);
        cyc(1'b1, FE_FIFO_CMD_DATA, 16'd3, 8'h03, 1'b0, 1'b0, 1'b1);
        chk("t6_en", 32'(O_wr_en), 32'd0);
        chk("t6_level", 32'(O_level), 32'd0);
        idle(1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] t;
            t = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 12)) : 16'($urandom);
            cyc($urandom_range(0, 9) < 7, 2'($urandom), t, 8'($urandom),
                $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 4,
                $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fe_fifo_packer.md
Name: fe_fifo_packer

Overview:
Downstream neighbour of the front-end capture FSM, in the fe_clk domain. Takes one capture event per cycle (write strobe, 2-bit command, full timestamp, data byte) and packs it into an 18-bit FIFO word. Small elastic buffer absorbs back-pressure from the main capture FIFO. Produces the sticky overflow-blocked flag that is fed back to the capture FSM.

Parameters:
pTIMESTAMP_FULL_WIDTH, 16, width of incoming timestamp; TIME words carry all of it
pTIMESTAMP_SHORT_WIDTH, 3, timestamp bits packed into non-TIME words (max 8)
pDEPTH_LOG2, 2, elastic buffer depth = 2**pDEPTH_LOG2 entries
pDROP_CNT_WIDTH, 16, width of dropped-event counter

Ports:
fe_clk  in  1  front-end clock; sole clock
reset_i  in  1  synchronous active-high reset
I_fifo_wr  in  1  event valid this cycle
I_fifo_command  in  2  FE_FIFO_CMD_* code
I_fifo_time  in  pTIMESTAMP_FULL_WIDTH  timestamp, aligned with I_fifo_wr
I_fifo_data  in  8  data byte, aligned with I_fifo_wr
I_flush  in  1  arm-time flush (already synchronised into fe_clk)
I_full  in  1  main capture FIFO full
O_wr_en  out  1  write strobe to main capture FIFO
O_wr_data  out  18  packed word
O_overflow_blocked  out  1  sticky: an event was dropped
O_clamped  out  1  sticky: a short timestamp was saturated
O_drop_count  out  pDROP_CNT_WIDTH  events dropped since flush, saturating
O_level  out  pDEPTH_LOG2+1  current buffer occupancy

Behaviour:
- Reset / I_flush: buffer emptied (pointers 0), O_overflow_blocked=0, O_clamped=0, O_drop_count=0, state ACTIVE. O_wr_en=0 and O_level=0 the following cycle. An input event present on the I_flush cycle is discarded.
- Packing, always applied to the accepted event:
  - TIME command: [17:16]=cmd, [15:0]=time[15:0].
  - Any other command: [17:16]=cmd, [15:8]=zero-extended short timestamp, [7:0]=data.
  - Short timestamp = time[pTIMESTAMP_SHORT_WIDTH-1:0] if time <= 2**pTIMESTAMP_SHORT_WIDTH-1; otherwise saturated to all-ones, and O_clamped is set.
- Buffer: circular, pointer width pDEPTH_LOG2+1; full when the MSBs differ and the LSBs are equal.
- Pop: O_wr_en = !empty & !I_full (combinational); O_wr_data = head entry (combinational). Pop happens when O_wr_en=1.
- Push: I_fifo_wr & state==ACTIVE & (!full | pop). Push and pop in the same cycle are legal at any occupancy; O_level is unchanged.
- Latency: an event accepted at edge N is on O_wr_data with O_wr_en=1 in the cycle after edge N, if the buffer was empty and I_full=0.
- Ordering: strict FIFO.
- FSM, 2 states:
  - ACTIVE -> BLOCKED when I_fifo_wr & full & !pop. That event is dropped, O_overflow_blocked is set, and O_drop_count increments.
  - BLOCKED: every I_fifo_wr is dropped and counted. The buffer keeps draining.
  - BLOCKED -> ACTIVE only on I_flush or reset.
- O_drop_count saturates at all-ones; no wrap.
- I_full held high indefinitely: buffer holds its contents and O_wr_en stays 0. There is no timeout.

Optional Feature:
FE_PACKER_STATS_EN
- Defined: adds outputs O_words_written[31:0] (pops since flush, wrapping) and O_max_level[pDEPTH_LOG2:0] (high-water mark since flush). Both clear on reset or I_flush.
- Undefined: these ports and their registers are absent. Core behaviour is identical.

Decomposition:
- Shared defines header: FE_FIFO_CMD_* codes (TIME code used for packing selection) and the 18-bit word field positions (CMD_MSB/LSB, SHORT_TS_MSB/LSB, DATA_MSB/LSB).
- One natural sub-module, fe_packer_buf: parameterised synchronous circular buffer with push, pop, flush, full, empty and level. The FSM, packing and counters live in the top.

Test Plan:
- Data event with time=5, cmd=DATA, data=0xA5, I_full=0 -> next cycle O_wr_en=1, O_wr_data={DATA,8'h05,8'hA5}, O_level returns to 0.
- TIME event with time=0x1234 -> O_wr_data={TIME,16'h1234}. Then a DATA event with time=12 and pTIMESTAMP_SHORT_WIDTH=3 -> short field 7 and O_clamped=1.
- I_full=1 with 6 back-to-back events at depth 4 -> 4 buffered, event 5 sets O_overflow_blocked and O_drop_count=1, event 6 makes it 2. Release I_full -> exactly 4 words emerge in order.
- Buffer full with I_full=0 and simultaneous push+pop for 10 cycles -> no drops, O_level stays 4, output order preserved.
- While BLOCKED, assert I_flush for one cycle with a concurrent event -> event discarded, O_level=0, O_drop_count=0, flag cleared; the next event is accepted.
- Assert reset_i mid-burst with buffer half full -> next cycle O_wr_en=0 and all outputs at reset values. With FE_PACKER_STATS_EN defined, O_max_level and O_words_written are also 0.
